gpr_wb_arbiter: RTL and testbench

//  Write-side controller for the general-purpose register file: owns its single write port (we_/wr_addr/wr_data).

---
 rtl/gpr_pkg.sv | 22 ++
 rtl/gpr_wb_lbuf.sv | 100 ++++++++++
 rtl/gpr_wb_arbiter.sv | 133 +++++++++++++
 tb/tb_gpr_wb_arbiter.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gpr_pkg.sv
// Shared definitions for the GPR write-side controller.
//   ADDR_W / DATA_W / REG_NUM : register file geometry
//   lbuf_state_t              : load-buffer occupancy state (EMPTY/ONE/TWO)
//   wb_entry_t                : one pending register write {addr, data}
package gpr_pkg;

  localparam int unsigned ADDR_W  = 5;
  localparam int unsigned DATA_W  = 32;
  localparam int unsigned REG_NUM = 2 ** ADDR_W;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } lbuf_state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/gpr_wb_lbuf.sv
// Two-entry FIFO holding load-return writes until the register file write
// port is free.
//   clk, reset   : clock, synchronous active-high reset
//   push_valid   : load return offered (transfers when push_ready is high)
//   push_entry   : load destination/data
//   push_ready   : buffer can accept (low in reset and when full)
//   pop          : consume head this cycle (ignored when empty)
//   head_valid   : head entry present
//   head         : oldest buffered entry
//   cnt          : occupancy 0..2
module gpr_wb_lbuf
  import gpr_pkg::*;
(
  input  logic      clk,
  input  logic      reset,
  input  logic      push_valid,
  input  wb_entry_t push_entry,
  output logic      push_ready,
  input  logic      pop,
  output logic      head_valid,
  output wb_entry_t head,
  output logic [1:0] cnt
);

  lbuf_state_t state_q, state_d;
  wb_entry_t   ent0_q, ent0_d;
  wb_entry_t   ent1_q, ent1_d;
  logic        do_push;
  logic        do_pop;

  assign do_push = push_valid & push_ready;
  assign do_pop  = pop & head_valid;
  assign head    = ent0_q;

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= EMPTY;
      ent0_q  <= '0;
      ent1_q  <= '0;
    end else begin
      state_q <= state_d;
      ent0_q  <= ent0_d;
      ent1_q  <= ent1_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      EMPTY: if (do_push) state_d = ONE;
      ONE: begin
        if (do_push && !do_pop)      state_d = TWO;
        else if (!do_push && do_pop) state_d = EMPTY;
      end
      TWO:     if (do_pop) state_d = ONE;
      default: state_d = EMPTY;
    endcase
  end

  // Entry storage: ent0 is always the head, ent1 the younger entry.
  // Push+pop in ONE writes the new entry straight into the head slot.
  always_comb begin
    ent0_d = ent0_q;
    ent1_d = ent1_q;
    unique case (state_q)
      EMPTY: if (do_push) ent0_d = push_entry;
      ONE: begin
        if (do_push) begin
          if (do_pop) ent0_d = push_entry;
          else        ent1_d = push_entry;
        end
      end
      TWO:     if (do_pop) ent0_d = ent1_q;
      default: ;
    endcase
  end

  // Outputs decoded from state
  always_comb begin
    push_ready = 1'b0;
    head_valid = 1'b0;
    cnt        = 2'd0;
    unique case (state_q)
      EMPTY: push_ready = ~reset;
      ONE: begin
        push_ready = ~reset;
        head_valid = 1'b1;
        cnt        = 2'd1;
      end
      TWO: begin
        head_valid = 1'b1;
        cnt        = 2'd2;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/gpr_wb_arbiter.sv
// Write-side controller for the general-purpose register file. Owns the
// single write port; ALU results (never stall) take priority over buffered
// load returns. Tracks registers with loads outstanding and flags decode
// reads of them.
//   clk, reset                     : clock, synchronous active-high reset
//   alu_valid/alu_addr/alu_data    : ALU writeback, always accepted
//   ld_valid/ld_ready/ld_addr/ld_data : load return handshake
//   ld_issue/ld_issue_addr         : load issued, mark destination pending
//   rd_addr_0/1, stall_0/1         : decode read addresses and stall flags
//   we_/wr_addr/wr_data            : registered write port (we_ active-low)
//   lbuf_cnt                       : load buffer occupancy
// Build option: GPR_WB_R0_DISCARD_EN makes register 0 a write sink
// (no write strobe, never pending, never stalls).
module gpr_wb_arbiter #(
  parameter int unsigned ADDR_W  = gpr_pkg::ADDR_W,
  parameter int unsigned DATA_W  = gpr_pkg::DATA_W,
  parameter int unsigned REG_NUM = gpr_pkg::REG_NUM
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              alu_valid,
  input  logic [ADDR_W-1:0] alu_addr,
  input  logic [DATA_W-1:0] alu_data,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  input  logic              ld_issue,
  input  logic [ADDR_W-1:0] ld_issue_addr,
  input  logic [ADDR_W-1:0] rd_addr_0,
  input  logic [ADDR_W-1:0] rd_addr_1,
  output logic              stall_0,
  output logic              stall_1,
  output logic              we_,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic [1:0]        lbuf_cnt
);

  import gpr_pkg::*;

`ifdef GPR_WB_R0_DISCARD_EN
  localparam bit R0_DISCARD = 1'b1;
`else
  localparam bit R0_DISCARD = 1'b0;
`endif

  logic               we_q, we_d;
  logic [ADDR_W-1:0]  wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0]  wr_data_q, wr_data_d;
  logic [REG_NUM-1:0] pending_q, pending_d;

  wb_entry_t lbuf_push_entry;
  wb_entry_t lbuf_head;
  logic      lbuf_head_valid;
  logic      lbuf_pop;
  logic      alu_sink;
  logic      head_sink;
  logic      issue_sink;

  assign lbuf_push_entry.addr = ld_addr;
  assign lbuf_push_entry.data = ld_data;

  gpr_wb_lbuf u_lbuf (
    .clk        (clk),
    .reset      (reset),
    .push_valid (ld_valid),
    .push_entry (lbuf_push_entry),
    .push_ready (ld_ready),
    .pop        (lbuf_pop),
    .head_valid (lbuf_head_valid),
    .head       (lbuf_head),
    .cnt        (lbuf_cnt)
  );

  assign alu_sink   = R0_DISCARD && (alu_addr == '0);
  assign head_sink  = R0_DISCARD && (lbuf_head.addr == '0);
  assign issue_sink = R0_DISCARD && (ld_issue_addr == '0);

  // Write-port arbitration. A discarded r0 write still consumes its slot
  // (and still pops a load) but leaves the port idle with addr/data held.
  always_comb begin
    we_d      = 1'b1;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    lbuf_pop  = 1'b0;
    if (alu_valid) begin
      if (!alu_sink) begin
        we_d      = 1'b0;
        wr_addr_d = alu_addr;
        wr_data_d = alu_data;
      end
    end else if (lbuf_head_valid) begin
      lbuf_pop = 1'b1;
      if (!head_sink) begin
        we_d      = 1'b0;
        wr_addr_d = lbuf_head.addr;
        wr_data_d = lbuf_head.data;
      end
    end
  end

  // Scoreboard: clear applied before set so a same-cycle issue wins.
  always_comb begin
    pending_d = pending_q;
    if (lbuf_pop)
      pending_d[lbuf_head.addr] = 1'b0;
    if (ld_issue && !issue_sink)
      pending_d[ld_issue_addr] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      we_q      <= 1'b1;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      pending_q <= '0;
    end else begin
      we_q      <= we_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      pending_q <= pending_d;
    end
  end

  assign we_     = we_q;
  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;

  assign stall_0 = pending_q[rd_addr_0] & ~(R0_DISCARD && (rd_addr_0 == '0));
  assign stall_1 = pending_q[rd_addr_1] & ~(R0_DISCARD && (rd_addr_1 == '0));

endmodule

// File: tb/tb_gpr_wb_arbiter.sv
module tb_gpr_wb_arbiter;

  logic        clk;
  logic        reset;
  logic        alu_valid;
  logic [4:0]  alu_addr;
  logic [31:0] alu_data;
  logic        ld_valid;
  logic        ld_ready;
  logic [4:0]  ld_addr;
  logic [31:0] ld_data;
  logic        ld_issue;
  logic [4:0]  ld_issue_addr;
  logic [4:0]  rd_addr_0;
  logic [4:0]  rd_addr_1;
  logic        stall_0;
  logic        stall_1;
  logic        we_;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic [1:0]  lbuf_cnt;

  gpr_wb_arbiter #(.ADDR_W(5), .DATA_W(32), .REG_NUM(32)) dut (
    .clk           (clk),
    .reset         (reset),
    .alu_valid     (alu_valid),
    .alu_addr      (alu_addr),
    .alu_data      (alu_data),
    .ld_valid      (ld_valid),
    .ld_ready      (ld_ready),
    .ld_addr       (ld_addr),
    .ld_data       (ld_data),
    .ld_issue      (ld_issue),
    .ld_issue_addr (ld_issue_addr),
    .rd_addr_0     (rd_addr_0),
    .rd_addr_1     (rd_addr_1),
    .stall_0       (stall_0),
    .stall_1       (stall_1),
    .we_           (we_),
    .wr_addr       (wr_addr),
    .wr_data       (wr_data),
    .lbuf_cnt      (lbuf_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0]  addr;
    logic [31:0] data;
  } exp_t;

  exp_t exp_q[$];
  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_wr(input logic [4:0] a, input logic [31:0] d);
    exp_t e;
    e.addr = a;
    e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic drive_alu(input logic v, input logic [4:0] a, input logic [31:0] d);
    alu_valid = v;
    alu_addr  = a;
    alu_data  = d;
  endtask

  task automatic drive_ld(input logic v, input logic [4:0] a, input logic [31:0] d);
    ld_valid = v;
    ld_addr  = a;
    ld_data  = d;
  endtask

  // Every observed register-file write must match the next scoreboard entry.
  always @(negedge clk) begin
    if (we_ === 1'b0) begin
      if (exp_q.size() == 0) begin
        check("unexpected_write", 64'(we_), 64'd1);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("wb_addr", 64'(wr_addr), 64'(e.addr));
        check("wb_data", 64'(wr_data), 64'(e.data));
      end
    end
  end

  initial begin
    reset = 1'b1;
    drive_alu(1'b0, 5'd0, 32'd0);
    drive_ld(1'b0, 5'd0, 32'd0);
    ld_issue = 1'b0;
    ld_issue_addr = 5'd0;
    rd_addr_0 = 5'd0;
    rd_addr_1 = 5'd0;
    tick();
    tick();

    // Reset state
    check("rst_we", 64'(we_), 64'd1);
    check("rst_addr", 64'(wr_addr), 64'd0);
    check("rst_data", 64'(wr_data), 64'd0);
    check("rst_cnt", 64'(lbuf_cnt), 64'd0);
    check("rst_ready", 64'(ld_ready), 64'd0);
    check("rst_stall0", 64'(stall_0), 64'd0);
    reset = 1'b0;
    #1;
    check("ready_after_rst", 64'(ld_ready), 64'd1);

    // 1: ALU only, latency 1
    drive_alu(1'b1, 5'd3, 32'hDEADBEEF);
    expect_wr(5'd3, 32'hDEADBEEF);
    tick();
    drive_alu(1'b0, 5'd0, 32'd0);
    check("t1_we", 64'(we_), 64'd0);
    check("t1_addr", 64'(wr_addr), 64'd3);
    check("t1_data", 64'(wr_data), 64'hDEADBEEF);
    tick();
    check("t1_we_idle", 64'(we_), 64'd1);
    check("t1_hold_addr", 64'(wr_addr), 64'd3);

    // 2: load issue -> stall, return -> write two cycles later
    ld_issue = 1'b1;
    ld_issue_addr = 5'd7;
    rd_addr_0 = 5'd7;
    tick();
    ld_issue = 1'b0;
    check("t2_stall_set", 64'(stall_0), 64'd1);
    tick();
    tick();
    tick();
    check("t2_ready", 64'(ld_ready), 64'd1);
    drive_ld(1'b1, 5'd7, 32'h55);
    expect_wr(5'd7, 32'h55);
    tick();
    drive_ld(1'b0, 5'd0, 32'd0);
    check("t2_cnt1", 64'(lbuf_cnt), 64'd1);
    check("t2_we_wait", 64'(we_), 64'd1);
    check("t2_stall_hold", 64'(stall_0), 64'd1);
    tick();
    check("t2_we", 64'(we_), 64'd0);
    check("t2_addr", 64'(wr_addr), 64'd7);
    check("t2_stall_clr", 64'(stall_0), 64'd0);
    check("t2_cnt0", 64'(lbuf_cnt), 64'd0);

    // 3: ALU stream starves loads; buffer fills and drains in order
    for (int unsigned i = 0; i < 4; i++) expect_wr(5'(10 + i), 32'hA0000000 + i);
    expect_wr(5'd14, 32'h50000001);
    expect_wr(5'd15, 32'h50000002);
    for (int unsigned i = 0; i < 4; i++) begin
      drive_alu(1'b1, 5'(10 + i), 32'hA0000000 + i);
      if (i == 0) drive_ld(1'b1, 5'd14, 32'h50000001);
      else if (i == 1) drive_ld(1'b1, 5'd15, 32'h50000002);
      else drive_ld(1'b0, 5'd0, 32'd0);
      if (i == 1) check("t3_cnt1", 64'(lbuf_cnt), 64'd1);
      if (i == 2) begin
        check("t3_cnt2", 64'(lbuf_cnt), 64'd2);
        check("t3_ready_full", 64'(ld_ready), 64'd0);
      end
      tick();
    end
    drive_alu(1'b0, 5'd0, 32'd0);
    check("t3_starved_cnt", 64'(lbuf_cnt), 64'd2);
    check("t3_starved_ready", 64'(ld_ready), 64'd0);
    tick();
    check("t3_first_ld", 64'(wr_addr), 64'd14);
    check("t3_cnt_drain", 64'(lbuf_cnt), 64'd1);
    tick();
    check("t3_second_ld", 64'(wr_addr), 64'd15);
    check("t3_cnt_empty", 64'(lbuf_cnt), 64'd0);
    tick();

    // 4: push+pop in ONE
    expect_wr(5'd20, 32'hA0000020);
    expect_wr(5'd21, 32'h44);
    expect_wr(5'd22, 32'h45);
    drive_alu(1'b1, 5'd20, 32'hA0000020);
    drive_ld(1'b1, 5'd21, 32'h44);
    tick();
    drive_alu(1'b0, 5'd0, 32'd0);
    check("t4_cnt1", 64'(lbuf_cnt), 64'd1);
    drive_ld(1'b1, 5'd22, 32'h45);
    tick();
    drive_ld(1'b0, 5'd0, 32'd0);
    check("t4_cnt_stay", 64'(lbuf_cnt), 64'd1);
    check("t4_older", 64'(wr_addr), 64'd21);
    tick();
    check("t4_newer", 64'(wr_addr), 64'd22);
    check("t4_cnt0", 64'(lbuf_cnt), 64'd0);
    tick();

    // 5: same-cycle set/clear of r9, set wins
    ld_issue = 1'b1;
    ld_issue_addr = 5'd9;
    rd_addr_1 = 5'd9;
    tick();
    ld_issue = 1'b0;
    check("t5_stall_set", 64'(stall_1), 64'd1);
    drive_ld(1'b1, 5'd9, 32'h99);
    expect_wr(5'd9, 32'h99);
    tick();
    drive_ld(1'b0, 5'd0, 32'd0);
    ld_issue = 1'b1;
    ld_issue_addr = 5'd9;
    tick();
    ld_issue = 1'b0;
    check("t5_we", 64'(we_), 64'd0);
    check("t5_set_wins", 64'(stall_1), 64'd1);
    drive_ld(1'b1, 5'd9, 32'h9A);
    expect_wr(5'd9, 32'h9A);
    tick();
    drive_ld(1'b0, 5'd0, 32'd0);
    check("t5_still_pending", 64'(stall_1), 64'd1);
    tick();
    check("t5_data", 64'(wr_data), 64'h9A);
    check("t5_cleared", 64'(stall_1), 64'd0);
    tick();

    // 6: reset with full buffer and pending bits
    expect_wr(5'd1, 32'hA6);
    expect_wr(5'd2, 32'hA7);
    expect_wr(5'd6, 32'hA8);
    drive_alu(1'b1, 5'd1, 32'hA6);
    ld_issue = 1'b1;
    ld_issue_addr = 5'd4;
    tick();
    drive_alu(1'b1, 5'd2, 32'hA7);
    ld_issue_addr = 5'd5;
    drive_ld(1'b1, 5'd4, 32'h64);
    tick();
    drive_alu(1'b1, 5'd6, 32'hA8);
    ld_issue = 1'b0;
    drive_ld(1'b1, 5'd5, 32'h65);
    tick();
    drive_alu(1'b0, 5'd0, 32'd0);
    drive_ld(1'b0, 5'd0, 32'd0);
    reset = 1'b1;
    rd_addr_0 = 5'd4;
    rd_addr_1 = 5'd5;
    #1;
    check("t6_pre_cnt", 64'(lbuf_cnt), 64'd2);
    check("t6_pre_stall0", 64'(stall_0), 64'd1);
    check("t6_pre_stall1", 64'(stall_1), 64'd1);
    check("t6_ready_in_rst", 64'(ld_ready), 64'd0);
    tick();
    check("t6_we", 64'(we_), 64'd1);
    check("t6_cnt", 64'(lbuf_cnt), 64'd0);
    check("t6_stall0", 64'(stall_0), 64'd0);
    check("t6_stall1", 64'(stall_1), 64'd0);
    check("t6_ready_rst_hi", 64'(ld_ready), 64'd0);
    reset = 1'b0;
    #1;
    check("t6_ready_release", 64'(ld_ready), 64'd1);
    tick();
    tick();

    // Register 0 handling
    drive_alu(1'b1, 5'd0, 32'hF0F0);
`ifndef GPR_WB_R0_DISCARD_EN
    expect_wr(5'd0, 32'hF0F0);
`endif
    tick();
    drive_alu(1'b0, 5'd0, 32'd0);
`ifdef GPR_WB_R0_DISCARD_EN
    check("r0_alu_we", 64'(we_), 64'd1);
`else
    check("r0_alu_we", 64'(we_), 64'd0);
`endif
    ld_issue = 1'b1;
    ld_issue_addr = 5'd0;
    rd_addr_0 = 5'd0;
    tick();
    ld_issue = 1'b0;
`ifdef GPR_WB_R0_DISCARD_EN
    check("r0_stall", 64'(stall_0), 64'd0);
`else
    check("r0_stall", 64'(stall_0), 64'd1);
`endif
    drive_ld(1'b1, 5'd0, 32'h0F);
`ifndef GPR_WB_R0_DISCARD_EN
    expect_wr(5'd0, 32'h0F);
`endif
    tick();
    drive_ld(1'b0, 5'd0, 32'd0);
    tick();
`ifdef GPR_WB_R0_DISCARD_EN
    check("r0_ld_we", 64'(we_), 64'd1);
`else
    check("r0_ld_we", 64'(we_), 64'd0);
`endif
    check("r0_ld_cnt", 64'(lbuf_cnt), 64'd0);
    check("r0_stall_clr", 64'(stall_0), 64'd0);
    tick();
    tick();

    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
